// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, constant IDs and the
// handler entry point used by the fetch redirect.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] PRID_VALUE   = 32'h0000_5707;
  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  function automatic logic [31:0] pack_sr(input sr_t sr);
    return {16'd0, sr.im, 8'd0, sr.exl, sr.ie};
  endfunction

  function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                             input logic [4:0] code);
    return {bd, 15'd0, ip, 3'd0, code, 2'b00};
  endfunction

endpackage

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC/PRId, interrupt and exception request generation,
// mtc0 writes and eret EXL clearing. Req is combinational from state and inputs.
module cp0
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  CP0Addr,
  input  logic [31:0] CP0WD,
  input  logic        CP0We,
  input  logic [31:0] PC_M,
  input  logic        BD_M,
  input  logic        ExcValid,
  input  logic [4:0]  ExcCode_M,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] CP0RD,
  output logic [31:0] EPC,
  output logic        Req
);

  sr_t         sr;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:2] epc_q;

  logic        int_req;
  logic        exc_req;
  logic        sr_we;
  logic        epc_we;
  logic [31:2] exc_epc;
  logic [1:0]  unused_pc_bits;

  assign int_req = (|(HWInt & sr.im)) & sr.ie & ~sr.exl;
  assign exc_req = ExcValid & ~sr.exl;
  assign Req     = int_req | exc_req;

  assign sr_we  = CP0We & ~Req & (CP0Addr == REG_SR);
  assign epc_we = CP0We & ~Req & (CP0Addr == REG_EPC);

  // A delay-slot fault restarts at the branch, one word before the faulting PC.
  assign exc_epc        = BD_M ? (PC_M[31:2] - 30'd1) : PC_M[31:2];
  assign unused_pc_bits = PC_M[1:0];

  assign EPC = {epc_q, 2'b00};

  always_comb begin
    CP0RD = 32'd0;
    case (CP0Addr)
      REG_SR:    CP0RD = pack_sr(sr);
      REG_CAUSE: CP0RD = pack_cause(bd, ip, exc_code);
      REG_EPC:   CP0RD = {epc_q, 2'b00};
      REG_PRID:  CP0RD = PRID_VALUE;
      default:   CP0RD = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr       <= '0;
      bd       <= 1'b0;
      ip       <= 6'd0;
      exc_code <= 5'd0;
      epc_q    <= '0;
    end else begin
      ip <= HWInt;
      if (Req) begin
        sr.exl   <= 1'b1;
        exc_code <= int_req ? EXC_INT : ExcCode_M;
        bd       <= BD_M;
        epc_q    <= exc_epc;
      end else begin
        if (sr_we) begin
          sr.im  <= CP0WD[15:10];
          sr.ie  <= CP0WD[0];
          sr.exl <= CP0WD[1];
        end
        if (epc_we) begin
          epc_q <= CP0WD[31:2];
        end
        // eret wins over a simultaneous mtc0 to SR.
        if (EXLClr) begin
          sr.exl <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0.sv
// Randomized and directed bench for cp0: a register-level reference model predicts
// each cycle's Req/CP0RD/EPC into a queue that a negedge monitor drains and compares.
module tb_cp0;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  CP0Addr;
  logic [31:0] CP0WD;
  logic        CP0We;
  logic [31:0] PC_M;
  logic        BD_M;
  logic        ExcValid;
  logic [4:0]  ExcCode_M;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] CP0RD;
  logic [31:0] EPC;
  logic        Req;

  cp0 dut (
    .clk(clk), .reset(reset), .CP0Addr(CP0Addr), .CP0WD(CP0WD), .CP0We(CP0We),
    .PC_M(PC_M), .BD_M(BD_M), .ExcValid(ExcValid), .ExcCode_M(ExcCode_M),
    .HWInt(HWInt), .EXLClr(EXLClr), .CP0RD(CP0RD), .EPC(EPC), .Req(Req)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic        req;
    logic [31:0] rd;
    logic [31:0] epc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state kept as whole 32-bit register images.
  logic [31:0] m_sr, m_cause, m_epc;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk) begin
        checks++;
        if (Req !== e.req) begin
          errors++;
          $display("FAIL req: got %b expected %b (addr=%0d t=%0t)", Req, e.req, CP0Addr, $time);
        end
        checks++;
        if (CP0RD !== e.rd) begin
          errors++;
          $display("FAIL cp0rd addr=%0d: got %h expected %h (t=%0t)", CP0Addr, CP0RD, e.rd, $time);
        end
        checks++;
        if (EPC !== e.epc) begin
          errors++;
          $display("FAIL epc: got %h expected %h (t=%0t)", EPC, e.epc, $time);
        end
      end
    end
  end

  task automatic idle();
    reset = 0; CP0Addr = 5'd0; CP0WD = 32'd0; CP0We = 0; PC_M = 32'd0; BD_M = 0;
    ExcValid = 0; ExcCode_M = 5'd0; HWInt = 6'd0; EXLClr = 0;
  endtask

  task automatic step(input bit chk);
    exp_t        e;
    logic        ireq, ereq, rq;
    logic [31:0] pcw;
    ireq = ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    ereq = ExcValid && !m_sr[1];
    rq   = ireq || ereq;
    e.chk = chk;
    e.req = rq;
    e.epc = m_epc;
    case (CP0Addr)
      5'd12:   e.rd = m_sr;
      5'd13:   e.rd = m_cause;
      5'd14:   e.rd = m_epc;
      5'd15:   e.rd = 32'h0000_5707;
      default: e.rd = 32'd0;
    endcase
    exp_q.push_back(e);
    @(posedge clk);
    if (reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      m_cause = (m_cause & ~32'h0000_FC00) | (32'(HWInt) << 10);
      if (rq) begin
        m_sr    = m_sr | 32'h2;
        m_cause = (m_cause & 32'h0000_FC00) | (BD_M ? 32'h8000_0000 : 32'd0)
                  | (ireq ? 32'd0 : (32'(ExcCode_M) << 2));
        pcw     = PC_M & ~32'h3;
        m_epc   = BD_M ? pcw - 32'd4 : pcw;
      end else begin
        if (CP0We && CP0Addr == 5'd12) m_sr = CP0WD & 32'h0000_FC03;
        if (CP0We && CP0Addr == 5'd14) m_epc = CP0WD & ~32'h3;
        if (EXLClr) m_sr = m_sr & ~32'h2;
      end
    end
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d, input logic clr);
    idle(); CP0We = 1; CP0Addr = a; CP0WD = d; EXLClr = clr; step(1);
  endtask

  task automatic rd(input logic [4:0] a, input logic [5:0] hw);
    idle(); CP0Addr = a; HWInt = hw; step(1);
  endtask

  initial begin
    m_sr = 0; m_cause = 0; m_epc = 0;
    idle();
    @(posedge clk); #1;
    reset = 1; step(0);
    reset = 1; CP0Addr = 5'd12; step(1);
    rd(5'd13, 0); rd(5'd14, 0); rd(5'd15, 0); rd(5'd20, 0);

    // Timer interrupt
    mtc0(5'd12, 32'h0000_0401, 0);
    idle(); HWInt = 6'b000001; PC_M = 32'h3008; CP0Addr = 5'd12; step(1);
    rd(5'd12, 6'b000001); rd(5'd13, 6'b000001); rd(5'd14, 6'b000001);

    // Delay-slot overflow
    mtc0(5'd12, 32'h0, 1);
    idle(); ExcValid = 1; ExcCode_M = 5'd12; PC_M = 32'h3010; BD_M = 1; CP0Addr = 5'd14; step(1);
    rd(5'd14, 0); rd(5'd13, 0); rd(5'd12, 0);

    // Masked interrupt
    mtc0(5'd12, 32'h0000_0001, 1);
    rd(5'd13, 6'b111111); rd(5'd13, 6'b111111); rd(5'd12, 0);

    // Nesting block then eret releases the pending interrupt
    mtc0(5'd12, 32'h0000_0403, 0);
    rd(5'd12, 6'b000001);
    idle(); HWInt = 6'b000001; EXLClr = 1; CP0Addr = 5'd12; step(1);
    idle(); HWInt = 6'b000001; PC_M = 32'h3018; CP0Addr = 5'd12; step(1);
    rd(5'd14, 0);

    // mtc0 EPC loses to a simultaneous interrupt
    mtc0(5'd12, 32'h0000_0401, 1);
    idle(); CP0We = 1; CP0Addr = 5'd14; CP0WD = 32'h5555; HWInt = 6'b000001; PC_M = 32'h3020; step(1);
    rd(5'd14, 0); rd(5'd12, 0);

    // Reset mid-handler
    idle(); reset = 1; CP0Addr = 5'd12; HWInt = 6'b000001; step(1);
    rd(5'd12, 0); rd(5'd13, 0); rd(5'd14, 0);

    // Unaligned EPC write, mtc0 plus eret on SR
    mtc0(5'd14, 32'h3007, 0);
    rd(5'd14, 0);
    mtc0(5'd12, 32'hFFFF_FFFE, 1);
    rd(5'd12, 0);
    mtc0(5'd13, 32'hFFFF_FFFF, 0);
    rd(5'd13, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      idle();
      reset     = ($urandom_range(0, 59) == 0);
      CP0Addr   = 5'($urandom_range(9, 17));
      CP0We     = ($urandom_range(0, 3) == 0);
      CP0WD     = $urandom;
      PC_M      = $urandom;
      BD_M      = 1'($urandom);
      ExcValid  = ($urandom_range(0, 7) == 0);
      ExcCode_M = 5'($urandom);
      HWInt     = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      EXLClr    = ($urandom_range(0, 5) == 0);
      step(1);
    end

    idle();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
